// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding and default width shared by the serial subtractor.
package serial_sub_pkg;
    localparam int SERIAL_SUB_N_DEF = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/serial_sub_fs_nand.sv
// fs_nand: one-bit full subtractor (a - b - bin) built only from NAND gates.
module fs_nand (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    logic n1, n2, n3, x, m1, m2, m3, na, nx, p, q;
    // x = a ^ b, diff = x ^ bin, bout = (~a & b) | (~x & bin)
    nand g1 (n1, a, b);
    nand g2 (n2, a, n1);
    nand g3 (n3, b, n1);
    nand g4 (x, n2, n3);
    nand g5 (m1, x, bin);
    nand g6 (m2, x, m1);
    nand g7 (m3, bin, m1);
    nand g8 (diff, m2, m3);
    nand g9 (na, a, a);
    nand g10 (p, na, b);
    nand g11 (nx, x, x);
    nand g12 (q, nx, bin);
    nand g13 (bout, p, q);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial N-bit subtractor computing a - b - bin LSB first over N cycles.
// Defining SERIAL_SUB_OVF_EN adds the registered signed-overflow output ovf.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int N = SERIAL_SUB_N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(N);
    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          br_q, br_d, bout_q, bout_d, d_bit, b_bit, last;
`ifdef SERIAL_SUB_OVF_EN
    logic          sa_q, sa_d, sb_q, sb_d, ovf_q, ovf_d;
`endif
    fs_nand u_fs (.a(a_q[0]), .b(b_q[0]), .bin(br_q), .diff(d_bit), .bout(b_bit));
    assign last = cnt_q == CW'(N - 1);
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
        ovf_d   = ovf_q;
`endif
        if (state_q == IDLE && start) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            br_d    = bin;
            cnt_d   = '0;
            diff_d  = '0;
`ifdef SERIAL_SUB_OVF_EN
            sa_d    = a[N-1];
            sb_d    = b[N-1];
`endif
        end else if (state_q == RUN) begin
            state_d = last ? DONE : RUN;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            br_d    = b_bit;
            cnt_d   = cnt_q + 1'b1;
            diff_d  = {d_bit, diff_q[N-1:1]};
            bout_d  = last ? b_bit : bout_q;
`ifdef SERIAL_SUB_OVF_EN
            // d_bit on the last cycle is the sign bit of the finished difference
            ovf_d   = last ? ((sa_q != sb_q) && (d_bit != sa_q)) : ovf_q;
`endif
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub (N = 8); checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;
    localparam int N = 8;
    typedef struct {
        logic [N-1:0] d;
        logic         bo;
        logic         ov;
        int           cyc;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [N-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif
    exp_t         sbq[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           n_done = 0;
    int           cyc = 0;

    serial_sub #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            n_done++;
            if (sbq.size() == 0) check("spurious_done", 1, 0);
            else begin
                e = sbq.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("bout", 32'(bout), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ov));
`endif
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi, input bit keep);
        exp_t         e;
        logic [N:0]   rhs;
        int           t;
        t = 0;
        while (busy && t < 4 * N) begin
            @(posedge clk);
            #1;
            t++;
        end
        a = av;
        b = bv;
        bin = bi;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (keep) begin
            rhs = {1'b0, bv} + (N + 1)'(bi);
            e.d = av - bv - N'(bi);
            e.bo = {1'b0, av} < rhs;
            e.ov = (av[N-1] != bv[N-1]) && (e.d[N-1] != av[N-1]);
            e.cyc = cyc + N;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_done();
        int target, t;
        target = n_done + 1;
        t = 0;
        while (n_done < target && t < 3 * N) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (n_done < target) check("done_timeout", 0, 1);
    endtask

    initial begin
        int n0, t;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_diff", 32'(diff), 0);
        check("rst_bout", 32'(bout), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(8'd100, 8'd37, 1'b0, 1);
        check("busy_run", 32'(busy), 1);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        check("hold_diff", 32'(diff), 63);
        check("idle_busy", 32'(busy), 0);
        run_op(8'd0, 8'd1, 1'b0, 1);
        wait_done();
        run_op(8'd5, 8'd5, 1'b1, 1);
        wait_done();
        run_op(8'h80, 8'h01, 1'b0, 1);
        wait_done();
        // abort after three bits have been processed
        n0 = n_done;
        run_op(8'd200, 8'd3, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_diff", 32'(diff), 0);
        repeat (N + 2) @(posedge clk);
        #1;
        check("abort_no_done", n_done - n0, 0);
        run_op(8'd9, 8'd4, 1'b0, 1);
        wait_done();
        // start pulses in RUN and in DONE must both be ignored
        n0 = n_done;
        run_op(8'd50, 8'd20, 1'b0, 1);
        repeat (2) @(posedge clk);
        #1;
        a = 8'd1;
        b = 8'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = 0;
        while (!done && t < 3 * N) begin
            @(negedge clk);
            t++;
        end
        if (!done) check("done_timeout", 0, 1);
        a = 8'd7;
        b = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2 * N) @(posedge clk);
        #1;
        check("one_done", n_done - n0, 1);
        check("ignored_busy", 32'(busy), 0);
        for (int i = 0; i < 6; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), 1);
            wait_done();
        end
        check("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial N-bit subtractor. Computes `a - b - bin` one bit per clock, LSB first. Each bit goes through a single full-subtractor cell, with the borrow carried in a flop between bits. It is the subtracting counterpart to the combinational full-adder cells in the arithmetic library, and it serves area-constrained datapaths that can tolerate N-cycle latency.

## Interface
- `N`, default 8: operand width. Legal range is N ≥ 2.
- `clk` (in, 1): single clock. All logic is rising-edge.
- `rst` (in, 1): synchronous, active-high reset.
- `start` (in, 1): request. Sampled only in IDLE.
- `a` (in, N): minuend. Captured when start is accepted.
- `b` (in, N): subtrahend. Captured when start is accepted.
- `bin` (in, 1): borrow-in. Captured when start is accepted.
- `busy` (out, 1): high in RUN and DONE.
- `done` (out, 1): one-cycle pulse. Result is valid.
- `diff` (out, N): difference register.
- `bout` (out, 1): final borrow-out.
- `ovf` (out, 1): signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN when `start` = 1.
  - RUN → DONE after the N-th bit.
  - DONE → IDLE unconditionally.
- **Accept (IDLE with start = 1):**
  - Load shift registers with `a` and `b`.
  - Load the borrow flop with `bin`.
  - Clear the bit counter to 0 and clear `diff`.
- **RUN, per cycle:**
  - `d = a0 ^ b0 ^ br`
  - `br_next = (~a0 & b0) | (~(a0 ^ b0) & br)`
  - Shift `d` into `diff` from the MSB side.
  - Shift the operand registers right.
  - Increment the counter. The counter width is `$clog2(N)`.
- **Result definition:**
  - `diff = (a - b - bin) mod 2^N`.
  - `bout = 1` exactly when `a < b + bin`, with the right side evaluated as an unsigned (N+1)-bit value.
- **start outside IDLE** (RUN or DONE): ignored. It is neither queued nor restarted. A request held high through DONE is accepted in the following IDLE cycle.
- **Output hold:** `diff`, `bout` and `ovf` hold their values from DONE until the next accepted start.
- **Reset mid-operation:** `rst` overrides all other activity.
  - State returns to IDLE.
  - No `done` pulse is produced.
  - The partial result is discarded.

## Timing
- **Reset values:**
  - state = IDLE
  - busy = 0, done = 0
  - diff = 0, bout = 0, ovf = 0
  - internal operand, borrow and counter registers = 0
- **Latency:**
  - `start` sampled at edge 0.
  - Bits processed at edges 1..N.
  - DONE is entered at edge N, so `done` = 1 and the result is valid during the cycle from edge N to edge N+1.
- **Throughput:** one operation per N+2 cycles. The extra cycles are the DONE cycle and one IDLE accept cycle.
- **busy:** rises in the cycle after the accept edge and falls on the edge where DONE → IDLE.
- **bout / ovf update:** both update at edge N, coincident with `diff` becoming complete.

## Configuration
- **`SERIAL_SUB_OVF_EN` defined:**
  - `ovf` port exists.
  - `ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1])`, evaluated on the captured operands.
  - The captured sign bits are kept in dedicated flops.
  - `ovf` is registered at edge N, held until the next accept, and reset to 0.
- **Undefined:** the `ovf` port and its sign flops are absent. All other behaviour is identical.

## Structure
- **Shared package `serial_sub_pkg`:**
  - state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2
  - default width constant `SERIAL_SUB_N_DEF` = 8
- **Sub-module `fs_nand`:** one-bit full-subtractor cell with ports `a`, `b`, `bin`, `diff`, `bout`. It is built purely from NAND primitives and instantiated once. The top level holds the FSM, shift registers, counter and borrow flop.

## Test plan
All scenarios use N = 8.
- **Basic subtract:** a = 100, b = 37, bin = 0, start for 1 cycle → `done` pulses at the 8th edge after accept, diff = 63, bout = 0, ovf = 0.
- **Wrap-around:** a = 0, b = 1, bin = 0 → diff = 8'hFF, bout = 1.
- **Borrow-in with equal operands:** a = 5, b = 5, bin = 1 → diff = 8'hFF, bout = 1.
- **Signed overflow:** a = 8'h80, b = 8'h01 → diff = 8'h7F, bout = 0, ovf = 1 (OVF_EN build).
- **Reset mid-operation:** `rst` asserted at RUN bit 3 → next cycle busy = 0, diff = 0, no `done`. A fresh start with a = 9, b = 4 then yields diff = 5.
- **start during busy:** start pulsed in RUN and in DONE with different operands → only the original result appears, and exactly one `done` pulse occurs.
